// File: rtl/xilinx_dual_port_asym_pipe_ram_pkg.sv
// Shared helpers for the asymmetric dual-port RAM: address math, clear FSM
// states and read-latency bounds.
package xtdp_ram_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic {CLEAR, READY} clrState_t;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    // Lane of a narrow word inside its wide word (lane 0 = LSBs).
    function automatic int laneIdx(input int narrowAddr, input int ratio);
        return narrowAddr % ratio;
    endfunction

    // Wide word holding a given narrow word.
    function automatic int wideIdx(input int narrowAddr, input int ratio);
        return narrowAddr / ratio;
    endfunction

endpackage

// File: rtl/xilinx_dual_port_asym_pipe_ram_rd_pipe.sv
// Read-latency pipeline: valid/data shift register whose last stage only
// loads on a valid beat, so the output holds its last value otherwise.
module ram_rd_pipe #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    output logic [WIDTH-1:0] outData
);

    logic [LATENCY-1:0] vldPipe;
    logic [WIDTH-1:0]   dataPipe [LATENCY];

    // Shift valid and data; the final stage updates only when its input is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vldPipe <= '0;
            for (int i = 0; i < LATENCY; i++) dataPipe[i] <= '0;
        end else begin
            vldPipe[0] <= inValid;
            if (LATENCY > 1 || inValid) dataPipe[0] <= inData;
            for (int i = 1; i < LATENCY; i++) begin
                vldPipe[i] <= vldPipe[i-1];
                if (i < LATENCY - 1 || vldPipe[i-1]) dataPipe[i] <= dataPipe[i-1];
            end
        end
    end

    assign outValid = vldPipe[LATENCY-1];
    assign outData  = dataPipe[LATENCY-1];

endmodule

// File: rtl/xilinx_dual_port_asym_pipe_ram.sv
// Single-clock true dual-port RAM, narrow port A and C_RATIO-times wider
// port B, with per-port read pipelines and collision flagging.
// Optional power-up clear of the whole array: define XTDP_RAM_INIT_CLEAR_EN.
module xilinx_dual_port_asym_pipe_ram
    import xtdp_ram_pkg::*;
#(
    parameter int C_RAM_A_WIDTH  = 16,
    parameter int C_RAM_A_DEPTH  = 1024,
    parameter int C_RATIO        = 2,
    parameter int C_RD_LATENCY_A = 1,
    parameter int C_RD_LATENCY_B = 1,
    localparam int C_RAM_B_WIDTH = C_RAM_A_WIDTH * C_RATIO,
    localparam int C_RAM_B_DEPTH = C_RAM_A_DEPTH / C_RATIO,
    localparam int ADDR_A_W      = clog2(C_RAM_A_DEPTH),
    localparam int ADDR_B_W      = clog2(C_RAM_B_DEPTH),
    localparam int POS_W         = clog2(C_RAM_B_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_A_W-1:0]      addrA,
    input  logic                     wrenA,
    input  logic [C_RAM_A_WIDTH-1:0] dinA,
    input  logic                     rdenA,
    output logic [C_RAM_A_WIDTH-1:0] doutA,
    output logic                     rdvalidA,
    input  logic [ADDR_B_W-1:0]      addrB,
    input  logic                     wrenB,
    input  logic [C_RAM_B_WIDTH-1:0] dinB,
    input  logic                     rdenB,
    output logic [C_RAM_B_WIDTH-1:0] doutB,
    output logic                     rdvalidB,
    output logic                     collision,
    output logic                     init_busy
);

    logic [C_RAM_B_WIDTH-1:0] mem [C_RAM_B_DEPTH];

    logic                     weA, weB, rdAccA, rdAccB;
    logic [ADDR_B_W-1:0]      wideAddrA;
    logic [POS_W-1:0]         laneBitA;
    logic [C_RAM_A_WIDTH-1:0] rdDataA;
    logic [C_RAM_B_WIDTH-1:0] rdDataB;
    logic                     clrWe;
    logic [ADDR_B_W-1:0]      clrAddr;
    logic                     portBWe;
    logic [ADDR_B_W-1:0]      portBAddr;
    logic [C_RAM_B_WIDTH-1:0] portBData;

    // While the clear runs the ports are fully ignored.
    assign weA    = wrenA & ~init_busy;
    assign weB    = wrenB & ~init_busy;
    assign rdAccA = rdenA & ~wrenA & ~init_busy;
    assign rdAccB = rdenB & ~wrenB & ~init_busy;

    assign wideAddrA = ADDR_B_W'(wideIdx(int'(addrA), C_RATIO));
    assign laneBitA  = POS_W'(laneIdx(int'(addrA), C_RATIO) * C_RAM_A_WIDTH);

    // Array is sampled at the request edge; writes land on the same edge, so
    // a cross-port read sees the old contents.
    assign rdDataA = mem[wideAddrA][laneBitA +: C_RAM_A_WIDTH];
    assign rdDataB = mem[addrB];

    // The clear borrows port B's write path; port B is gated off meanwhile.
    assign portBWe   = clrWe | weB;
    assign portBAddr = clrWe ? clrAddr : addrB;
    assign portBData = clrWe ? '0 : dinB;

    // Memory write: port A's lane is written last so it wins an overlap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (portBWe) mem[portBAddr] <= portBData;
            if (weA)     mem[wideAddrA][laneBitA +: C_RAM_A_WIDTH] <= dinA;
        end
    end

    // One-cycle flag for two writes hitting the same wide word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) collision <= 1'b0;
        else     collision <= weA & weB & (wideAddrA == addrB);
    end

`ifdef XTDP_RAM_INIT_CLEAR_EN
    clrState_t clrState;

    // Clear FSM: zero one wide word per cycle after reset, then go ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clrState  <= CLEAR;
            clrAddr   <= '0;
            init_busy <= 1'b1;
        end else begin
            case (clrState)
                CLEAR: begin
                    clrAddr <= clrAddr + ADDR_B_W'(1);
                    if (clrAddr == ADDR_B_W'(C_RAM_B_DEPTH - 1)) begin
                        clrState  <= READY;
                        init_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign clrWe = (clrState == CLEAR);
`else
    assign init_busy = 1'b0;
    assign clrWe     = 1'b0;
    assign clrAddr   = '0;
`endif

    ram_rd_pipe #(.WIDTH(C_RAM_A_WIDTH), .LATENCY(C_RD_LATENCY_A)) u_pipeA (
        .clk      (clk),
        .rst      (rst),
        .inValid  (rdAccA),
        .inData   (rdDataA),
        .outValid (rdvalidA),
        .outData  (doutA)
    );

    ram_rd_pipe #(.WIDTH(C_RAM_B_WIDTH), .LATENCY(C_RD_LATENCY_B)) u_pipeB (
        .clk      (clk),
        .rst      (rst),
        .inValid  (rdAccB),
        .inData   (rdDataB),
        .outValid (rdvalidB),
        .outData  (doutB)
    );

endmodule

// File: tb/tb_xilinx_dual_port_asym_pipe_ram.sv
// Randomized bench for the asymmetric dual-port RAM against an array/queue
// reference model. Honours XTDP_RAM_INIT_CLEAR_EN when defined.
module tb_xilinx_dual_port_asym_pipe_ram;

    localparam int AW    = 16;
    localparam int AD    = 64;
    localparam int RATIO = 2;
    localparam int LAT_A = 3;
    localparam int LAT_B = 2;
    localparam int BW    = AW * RATIO;
    localparam int BD    = AD / RATIO;
`ifdef XTDP_RAM_INIT_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    addrA;
    logic          wrenA, rdenA;
    logic [AW-1:0] dinA, doutA;
    logic          rdvalidA;
    logic [4:0]    addrB;
    logic          wrenB, rdenB;
    logic [BW-1:0] dinB, doutB;
    logic          rdvalidB, collision, init_busy;

    xilinx_dual_port_asym_pipe_ram #(
        .C_RAM_A_WIDTH(AW), .C_RAM_A_DEPTH(AD), .C_RATIO(RATIO),
        .C_RD_LATENCY_A(LAT_A), .C_RD_LATENCY_B(LAT_B)
    ) dut (
        .clk(clk), .rst(rst),
        .addrA(addrA), .wrenA(wrenA), .dinA(dinA), .rdenA(rdenA),
        .doutA(doutA), .rdvalidA(rdvalidA),
        .addrB(addrB), .wrenB(wrenB), .dinB(dinB), .rdenB(rdenB),
        .doutB(doutB), .rdvalidB(rdvalidB),
        .collision(collision), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [BW-1:0] data;
    } rd_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            busyCnt;
    rd_t           qA[$];
    rd_t           qB[$];
    logic [BW-1:0] mdl [BD];
    logic [BW-1:0] heldA, heldB;
    logic          expColl;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock: update the model from the sampled inputs, then compare.
    task automatic step();
        bit  busy, weA, weB;
        int  wa, lane;
        rd_t e;
        @(posedge clk);
        cyc++;
        expColl = 1'b0;
        if (!rst) begin
            busy = (busyCnt > 0);
            wa   = int'(addrA) / RATIO;
            lane = int'(addrA) % RATIO;
            weA  = wrenA && !busy;
            weB  = wrenB && !busy;
            if (rdenA && !wrenA && !busy) begin
                e.due  = cyc + LAT_A - 1;
                e.data = '0;
                e.data[AW-1:0] = mdl[wa][lane*AW +: AW];
                qA.push_back(e);
            end
            if (rdenB && !wrenB && !busy) begin
                e.due  = cyc + LAT_B - 1;
                e.data = mdl[addrB];
                qB.push_back(e);
            end
            expColl = weA && weB && (wa == int'(addrB));
            if (weB) mdl[addrB] = dinB;
            if (weA) mdl[wa][lane*AW +: AW] = dinA;
            if (busy) busyCnt--;
        end
        #1;
        if (qA.size() > 0 && qA[0].due == cyc) begin
            heldA = qA[0].data;
            void'(qA.pop_front());
            chk("rdvalidA", 64'(rdvalidA), 64'd1);
        end else begin
            chk("rdvalidA", 64'(rdvalidA), 64'd0);
        end
        if (qB.size() > 0 && qB[0].due == cyc) begin
            heldB = qB[0].data;
            void'(qB.pop_front());
            chk("rdvalidB", 64'(rdvalidB), 64'd1);
        end else begin
            chk("rdvalidB", 64'(rdvalidB), 64'd0);
        end
        chk("doutA", 64'(doutA), 64'(heldA[AW-1:0]));
        chk("doutB", 64'(doutB), 64'(heldB));
        chk("collision", 64'(collision), 64'(expColl));
        chk("init_busy", 64'(init_busy), 64'(busyCnt > 0));
    endtask

    task automatic op(input bit wa, input int aa, input int da, input bit ra,
                      input bit wb, input int ab, input logic [BW-1:0] db, input bit rb);
        wrenA = wa; addrA = 6'(aa); dinA = 16'(da); rdenA = ra;
        wrenB = wb; addrB = 5'(ab); dinB = db;      rdenB = rb;
        step();
    endtask

    task automatic idle();
        op(0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic modelReset();
        qA.delete();
        qB.delete();
        heldA   = '0;
        heldB   = '0;
        expColl = 1'b0;
        busyCnt = CLR ? BD : 0;
        if (CLR) for (int i = 0; i < BD; i++) mdl[i] = '0;
    endtask

    // Mid-run reset: outputs must drop at once, without waiting for a clock.
    task automatic doReset();
        rst = 1'b1;
        modelReset();
        #1;
        chk("rst_doutA", 64'(doutA), 64'd0);
        chk("rst_doutB", 64'(doutB), 64'd0);
        chk("rst_rdvalidA", 64'(rdvalidA), 64'd0);
        chk("rst_rdvalidB", 64'(rdvalidB), 64'd0);
        chk("rst_collision", 64'(collision), 64'd0);
        repeat (2) step();
        rst = 1'b0;
    endtask

    // Random traffic during the clear; every access must be ignored.
    task automatic waitClear();
        while (busyCnt > 0)
            op($urandom_range(0, 1), $urandom_range(0, AD-1), $urandom, $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, BD-1), $urandom, $urandom_range(0, 1));
    endtask

    initial begin
        rst = 1'b1;
        wrenA = 0; addrA = '0; dinA = '0; rdenA = 0;
        wrenB = 0; addrB = '0; dinB = '0; rdenB = 0;
        modelReset();
        repeat (2) step();
        rst = 1'b0;
        waitClear();
        if (CLR) begin
            for (int b = 0; b < BD; b++) op(0, 0, 0, 0, 0, b, '0, 1);
            repeat (LAT_B) idle();
        end

        // Load every wide word so later reads are fully predictable.
        for (int b = 0; b < BD; b++) op(0, 0, 0, 0, 1, b, $urandom, 0);

        // Two narrow writes assembled into one wide read.
        op(1, 5, 'h1111, 0, 0, 0, '0, 0);
        op(1, 4, 'h2222, 0, 0, 0, '0, 0);
        op(0, 0, 0, 0, 0, 2, '0, 1);
        repeat (LAT_B - 1) idle();
        chk("tp_wideB", 64'(doutB), 64'h11112222);
        repeat (2) idle();

        // Back-to-back narrow reads through the 3-deep pipe.
        for (int a = 0; a < 4; a++) op(0, a, 0, 1, 0, 0, '0, 0);
        repeat (LAT_A + 1) idle();

        // Overlapping writes to the same wide word.
        op(1, 7, 'hAAAA, 0, 1, 3, 32'h12345678, 0);
        chk("tp_coll_hit", 64'(collision), 64'd1);
        idle();
        chk("tp_coll_drop", 64'(collision), 64'd0);
        op(0, 0, 0, 0, 0, 3, '0, 1);
        repeat (LAT_B - 1) idle();
        chk("tp_coll_word", 64'(doutB), 64'hAAAA5678);
        op(1, 7, 'h5555, 0, 1, 2, 32'h0BADF00D, 0);
        chk("tp_coll_none", 64'(collision), 64'd0);

        // Write with read on the same port: write only, no valid.
        op(1, 9, 'hBEEF, 1, 0, 0, '0, 0);
        repeat (LAT_A) idle();
        op(0, 9, 0, 1, 0, 0, '0, 0);
        repeat (LAT_A) idle();

        // Reset with reads in flight on both ports.
        op(0, 1, 0, 1, 0, 1, '0, 1);
        op(0, 2, 0, 1, 0, 2, '0, 1);
        doReset();
        waitClear();
        repeat (LAT_A + 1) idle();

        // Random mixed traffic, addresses biased into a small window for overlaps.
        for (int n = 0; n < 400; n++) begin
            bit narrow = ($urandom_range(0, 1) == 1);
            op($urandom_range(0, 2) == 0, narrow ? $urandom_range(0, 7) : $urandom_range(0, AD-1),
               $urandom, $urandom_range(0, 1),
               $urandom_range(0, 2) == 0, narrow ? $urandom_range(0, 3) : $urandom_range(0, BD-1),
               $urandom, $urandom_range(0, 1));
        end
        repeat (LAT_A + LAT_B) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
